// File: rtl/fork_butler.sv
// fork_butler: central fork arbiter for an N-seat dining-philosophers ring.
// Round-robin grant with starvation aging; at most one new grant per cycle.
module fork_butler #(
    parameter int N        = 8,
    parameter int AGE_W    = 4,
    parameter int MAX_WAIT = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] hungry,
    input  logic [N-1:0] done,
    output logic [N-1:0] eat,
    output logic [N-1:0] fork_busy,
    output logic [N-1:0] starve
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, WAIT, EAT} state_t;

    state_t           st     [N];
    state_t           st_nx  [N];
    logic [AGE_W-1:0] age    [N];
    logic [AGE_W-1:0] age_nx [N];
    logic [PW-1:0]    rr, rr_nx;
    logic [N-1:0]     waiting, elig, cand, grant;
    logic             found;
    int               idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eat[i]     = st[i] == EAT;
            waiting[i] = st[i] == WAIT;
            starve[i]  = waiting[i] && age[i] >= AGE_W'(MAX_WAIT);
        end
        // fork j is held by seat j or seat j-1
        fork_busy = eat | {eat[N-2:0], eat[N-1]};
        elig      = waiting & hungry & ~fork_busy & ~{fork_busy[0], fork_busy[N-1:1]};
        cand      = |starve ? elig & starve : elig;
        grant     = '0;
        rr_nx     = rr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr) + k) % N;
            if (!found && cand[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                rr_nx      = PW'((idx + 1) % N);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_nx[i]  = st[i];
            age_nx[i] = age[i];
            if (st[i] == IDLE && hungry[i]) begin
                st_nx[i]  = WAIT;
                age_nx[i] = '0;
            end else if (st[i] == WAIT) begin
                st_nx[i]  = grant[i] ? EAT : hungry[i] ? WAIT : IDLE;
                age_nx[i] = (grant[i] || !hungry[i]) ? '0 : (&age[i]) ? age[i] : age[i] + 1'b1;
            end else if (st[i] == EAT && done[i]) begin
                st_nx[i] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                st[i]  <= IDLE;
                age[i] <= '0;
            end
            rr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st[i]  <= st_nx[i];
                age[i] <= age_nx[i];
            end
            rr <= rr_nx;
        end
    end
endmodule

// File: tb/tb_fork_butler.sv
// tb_fork_butler: directed scenarios for fork_butler, checked every cycle
// against a seat/fork-ownership model plus hand-computed expectations.
module tb_fork_butler;
    localparam int N      = 8;
    localparam int MAXW   = 12;
    localparam int AGEMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hungry = '0;
    logic [7:0] done = '0;
    logic [7:0] eat, fork_busy, starve;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fork_butler #(.N(N), .AGE_W(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .hungry(hungry), .done(done),
        .eat(eat), .fork_busy(fork_busy), .starve(starve)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // model: seat mode 0=idle 1=waiting 2=eating, waiting age, next seat to favour
    int m_st[N], m_age[N], m_rr;
    int n_st[N], n_age[N], n_rr;
    int owner[N];
    int g, s;
    bit anys;
    logic [7:0] m_eat, m_busy, m_starve;

    always_comb begin
        m_eat = '0;
        m_busy = '0;
        m_starve = '0;
        anys = 1'b0;
        g = -1;
        s = 0;
        for (int j = 0; j < N; j++) owner[j] = -1;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 2) begin
                owner[i] = i;
                owner[(i + 1) % N] = i;
                m_eat[i] = 1'b1;
                m_busy[i] = 1'b1;
                m_busy[(i + 1) % N] = 1'b1;
            end
            if (m_st[i] == 1 && m_age[i] >= MAXW) begin
                anys = 1'b1;
                m_starve[i] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            s = (m_rr + k) % N;
            if (g < 0 && m_st[s] == 1 && hungry[s] && owner[s] < 0 && owner[(s + 1) % N] < 0
                && (!anys || m_age[s] >= MAXW))
                g = s;
        end
        n_rr = (g >= 0) ? (g + 1) % N : m_rr;
        for (int i = 0; i < N; i++) begin
            n_st[i] = m_st[i];
            n_age[i] = m_age[i];
            if (m_st[i] == 0 && hungry[i]) begin
                n_st[i] = 1;
                n_age[i] = 0;
            end else if (m_st[i] == 1 && i == g) begin
                n_st[i] = 2;
                n_age[i] = 0;
            end else if (m_st[i] == 1 && !hungry[i]) begin
                n_st[i] = 0;
                n_age[i] = 0;
            end else if (m_st[i] == 1) begin
                n_age[i] = (m_age[i] + 1 > AGEMAX) ? AGEMAX : m_age[i] + 1;
            end else if (m_st[i] == 2 && done[i]) begin
                n_st[i] = 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] <= 0;
                m_age[i] <= 0;
            end
            m_rr <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_st[i] <= n_st[i];
                m_age[i] <= n_age[i];
            end
            m_rr <= n_rr;
        end
    end

    always @(negedge clk) begin
        check("eat", eat, m_eat);
        check("fork_busy", fork_busy, m_busy);
        check("starve", starve, m_starve);
        check("adjacent_eat", eat & {eat[6:0], eat[7]}, 8'h00);
        check("fork_count", 8'($countones(fork_busy)), 8'(2 * $countones(eat)));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        hungry = '0;
        done = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_eat", eat, 8'h00);
        check("rst_busy", fork_busy, 8'h00);
        check("rst_starve", starve, 8'h00);
        rst_n = 1'b1;

        // single seat
        hungry = 8'h08;
        tick();
        check("t1_wait_eat", eat, 8'h00);
        tick();
        check("t1_eat", eat, 8'h08);
        check("t1_busy", fork_busy, 8'h18);
        done = 8'h08;
        hungry = 8'h00;
        tick();
        check("t1_rel_eat", eat, 8'h00);
        check("t1_rel_busy", fork_busy, 8'h00);
        done = 8'h00;

        // everyone hungry
        reset_dut();
        hungry = 8'hFF;
        tick();
        tick();
        check("t2_g0", eat, 8'h01);
        tick();
        check("t2_g2", eat, 8'h05);
        tick();
        check("t2_g4", eat, 8'h15);
        tick();
        check("t2_g6", eat, 8'h55);
        check("t2_busy", fork_busy, 8'hFF);
        repeat (7) tick();
        check("t2_no_starve", starve, 8'h00);
        tick();
        check("t2_starve", starve, 8'hAA);
        check("t2_hold", eat, 8'h55);

        // asynchronous reset between edges, then fresh rr_ptr
        #2 rst_n = 1'b0;
        #1;
        check("t6_eat", eat, 8'h00);
        check("t6_busy", fork_busy, 8'h00);
        check("t6_starve", starve, 8'h00);
        hungry = 8'h00;
        tick();
        rst_n = 1'b1;
        hungry = 8'h84;
        tick();
        tick();
        check("t6_rr0", eat, 8'h04);
        tick();
        check("t6_both", eat, 8'h84);

        // contention around a release
        reset_dut();
        hungry = 8'h04;
        tick();
        tick();
        check("t3_seat2", eat, 8'h04);
        hungry = 8'h0E;
        tick();
        tick();
        check("t3_blocked", eat, 8'h04);
        hungry = 8'h0A;
        done = 8'h04;
        tick();
        check("t3_release", eat, 8'h00);
        check("t3_free", fork_busy, 8'h00);
        done = 8'h00;
        tick();
        check("t3_seat3", eat, 8'h08);
        tick();
        check("t3_seat1", eat, 8'h0A);
        check("t3_busy", fork_busy, 8'h1E);

        // starvation
        reset_dut();
        hungry = 8'h05;
        tick();
        tick();
        check("t4_g0", eat, 8'h01);
        tick();
        check("t4_g2", eat, 8'h05);
        hungry = 8'h27;
        tick();
        tick();
        check("t4_seat5", eat, 8'h25);
        done = 8'h20;
        hungry = 8'h07;
        tick();
        check("t4_rel5", eat, 8'h05);
        done = 8'h00;
        repeat (9) tick();
        check("t4_age11", starve, 8'h00);
        tick();
        check("t4_age12", starve, 8'h02);
        hungry = 8'h27;
        tick();
        tick();
        check("t4_5_blocked", eat, 8'h05);
        tick();
        check("t4_5_still", eat, 8'h05);
        check("t4_starve_hold", starve, 8'h02);
        done = 8'h05;
        hungry = 8'h22;
        tick();
        check("t4_release", eat, 8'h00);
        done = 8'h00;
        tick();
        check("t4_seat1", eat, 8'h02);
        check("t4_cleared", starve, 8'h00);
        tick();
        check("t4_seat5_late", eat, 8'h22);

        // withdraw
        reset_dut();
        hungry = 8'h08;
        tick();
        tick();
        check("t5_seat3", eat, 8'h08);
        hungry = 8'h18;
        repeat (3) tick();
        check("t5_blocked", eat, 8'h08);
        hungry = 8'h08;
        tick();
        check("t5_withdraw", eat, 8'h08);
        hungry = 8'h18;
        tick();
        repeat (11) tick();
        check("t5_age11", starve, 8'h00);
        tick();
        check("t5_age12", starve, 8'h10);
        done = 8'h08;
        hungry = 8'h10;
        tick();
        done = 8'h00;
        tick();
        check("t5_seat4", eat, 8'h10);
        check("t5_cleared", starve, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
